// File: rtl/scroll_y_line_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : scroll_y_line_gen_if
// Description : Bundle of the scroll/raster signals between the video timing
//               side (master) and the scroll line generator (slave).
//               Optional raster IRQ signals exist when SCROLL_RASTER_IRQ_EN
//               is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface scroll_y_line_gen_if #(
  parameter int TILE_H_LOG2 = 3
);
  logic [7:0]             scroll_y;
  logic                   vsync_start;
  logic                   hline_start;
  logic [7:0]             frame_scroll;
  logic [7-TILE_H_LOG2:0] map_row;
  logic [TILE_H_LOG2-1:0] tile_line;
  logic                   line_valid;
  logic                   frame_active;
`ifdef SCROLL_RASTER_IRQ_EN
  logic [7:0]             irq_line;
  logic                   raster_irq;

  modport master (
    output scroll_y, vsync_start, hline_start, irq_line,
    input  frame_scroll, map_row, tile_line, line_valid, frame_active, raster_irq
  );
  modport slave (
    input  scroll_y, vsync_start, hline_start, irq_line,
    output frame_scroll, map_row, tile_line, line_valid, frame_active, raster_irq
  );
`else
  modport master (
    output scroll_y, vsync_start, hline_start,
    input  frame_scroll, map_row, tile_line, line_valid, frame_active
  );
  modport slave (
    input  scroll_y, vsync_start, hline_start,
    output frame_scroll, map_row, tile_line, line_valid, frame_active
  );
`endif
endinterface
`default_nettype wire

// File: rtl/scroll_y_line_gen.sv
`default_nettype none
// ============================================================================
// Module      : scroll_y_line_gen
// Description : Latches the CPU vertical scroll once per frame at vsync and
//               turns each visible line into a tile-map row / pixel row pair,
//               wrapped over the 256-line map.
//               Optional feature macro: SCROLL_RASTER_IRQ_EN (raster IRQ).
// Revision    : 1.0 - initial release
// ============================================================================
module scroll_y_line_gen #(
  parameter int VISIBLE_LINES = 240,
  parameter int TILE_H_LOG2   = 3
) (
  input  logic                clk,
  input  logic                reset,
  scroll_y_line_gen_if.slave  bus
);

  localparam int         c_ROW_W     = 8 - TILE_H_LOG2;
  localparam logic [7:0] c_LAST_LINE = 8'(VISIBLE_LINES - 1);

  localparam logic [1:0] c_WAIT_VS = 2'd0;
  localparam logic [1:0] c_ACTIVE  = 2'd1;
  localparam logic [1:0] c_DONE    = 2'd2;

  logic [1:0]             state_q,        state_d;
  logic [7:0]             line_cnt_q,     line_cnt_d;
  logic [7:0]             frame_scroll_q, frame_scroll_d;
  logic [c_ROW_W-1:0]     map_row_q,      map_row_d;
  logic [TILE_H_LOG2-1:0] tile_line_q,    tile_line_d;
  logic                   line_valid_q,   line_valid_d;

  // Line being serviced this cycle: base scroll and index, which are the
  // incoming values when vsync and hline coincide.
  logic                   w_serve;
  logic [7:0]             w_base;
  logic [7:0]             w_cnt;
  logic [7:0]             w_eff;

`ifdef SCROLL_RASTER_IRQ_EN
  logic                   raster_irq_q,   raster_irq_d;
`endif

  // Next-state logic: vsync restarts the frame from any state; lines are
  // serviced only while the frame is active (or on the vsync cycle itself).
  always_comb begin
    state_d        = state_q;
    line_cnt_d     = line_cnt_q;
    frame_scroll_d = frame_scroll_q;
    map_row_d      = map_row_q;
    tile_line_d    = tile_line_q;
    line_valid_d   = 1'b0;
    w_serve        = 1'b0;
    w_base         = frame_scroll_q;
    w_cnt          = line_cnt_q;
    w_eff          = 8'd0;

    if (bus.vsync_start) begin
      frame_scroll_d = bus.scroll_y;
      line_cnt_d     = 8'd0;
      state_d        = c_ACTIVE;
      w_base         = bus.scroll_y;
      w_cnt          = 8'd0;
      w_serve        = bus.hline_start;
    end else if (state_q == c_ACTIVE) begin
      w_serve        = bus.hline_start;
    end

    if (w_serve) begin
      w_eff        = w_cnt + w_base;
      map_row_d    = w_eff[7:TILE_H_LOG2];
      tile_line_d  = w_eff[TILE_H_LOG2-1:0];
      line_valid_d = 1'b1;
      line_cnt_d   = w_cnt + 8'd1;
      if (w_cnt == c_LAST_LINE) begin
        state_d = c_DONE;
      end
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= c_WAIT_VS;
      line_cnt_q     <= 8'd0;
      frame_scroll_q <= 8'd0;
      map_row_q      <= '0;
      tile_line_q    <= '0;
      line_valid_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      line_cnt_q     <= line_cnt_d;
      frame_scroll_q <= frame_scroll_d;
      map_row_q      <= map_row_d;
      tile_line_q    <= tile_line_d;
      line_valid_q   <= line_valid_d;
    end
  end

`ifdef SCROLL_RASTER_IRQ_EN
  // Raster IRQ: pulse with line_valid when the serviced line index matches.
  always_comb begin
    raster_irq_d = w_serve && (w_cnt == bus.irq_line);
  end

  // Raster IRQ register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      raster_irq_q <= 1'b0;
    end else begin
      raster_irq_q <= raster_irq_d;
    end
  end

  assign bus.raster_irq = raster_irq_q;
`endif

  assign bus.frame_scroll = frame_scroll_q;
  assign bus.map_row      = map_row_q;
  assign bus.tile_line    = tile_line_q;
  assign bus.line_valid   = line_valid_q;
  assign bus.frame_active = (state_q == c_ACTIVE);

endmodule
`default_nettype wire

// File: tb/tb_scroll_y_line_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_scroll_y_line_gen
// Description : Self-checking bench for scroll_y_line_gen: directed frames
//               followed by random vsync/hline/scroll traffic, compared to a
//               frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scroll_y_line_gen;

  localparam int VL = 240;
  localparam int T  = 3;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  scroll_y_line_gen_if #(.TILE_H_LOG2(T)) bus ();

  scroll_y_line_gen #(.VISIBLE_LINES(VL), .TILE_H_LOG2(T)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: lines served since the last vsync and whether the
  // frame still has lines left to service.
  int m_scroll, m_n, m_map, m_tile, m_valid, m_active, m_irq;
  int irq_sel = 2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_scroll = 0; m_n = 0; m_map = 0; m_tile = 0;
    m_valid = 0; m_active = 0; m_irq = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"},  32'(bus.line_valid),   32'(m_valid));
    chk({tag, ".active"}, 32'(bus.frame_active), 32'(m_active));
    chk({tag, ".fscroll"},32'(bus.frame_scroll), 32'(m_scroll));
    chk({tag, ".map"},    32'(bus.map_row),      32'(m_map));
    chk({tag, ".tile"},   32'(bus.tile_line),    32'(m_tile));
`ifdef SCROLL_RASTER_IRQ_EN
    chk({tag, ".irq"},    32'(bus.raster_irq),   32'(m_irq));
`endif
  endtask

  // One clock of stimulus: drive at negedge, update model, check after posedge.
  task automatic step(input string tag, input bit vs, input bit hl, input logic [7:0] sy);
    int eff;
    @(negedge clk);
    bus.scroll_y    = sy;
    bus.vsync_start = vs;
    bus.hline_start = hl;
`ifdef SCROLL_RASTER_IRQ_EN
    bus.irq_line    = 8'(irq_sel);
`endif
    m_valid = 0;
    m_irq   = 0;
    if (vs) begin
      m_scroll = int'(sy);
      m_n      = 0;
      m_active = 1;
    end
    if (hl && m_active != 0 && m_n < VL) begin
      eff     = (m_n + m_scroll) % 256;
      m_map   = eff / (1 << T);
      m_tile  = eff % (1 << T);
      m_valid = 1;
      m_irq   = (m_n == irq_sel) ? 1 : 0;
      m_n++;
    end
    if (m_n >= VL) m_active = 0;
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  int cnt_valid;
  int cnt_irq;
  logic [7:0] cur_sy;

  initial begin
    bus.scroll_y    = 8'h00;
    bus.vsync_start = 1'b0;
    bus.hline_start = 1'b0;
`ifdef SCROLL_RASTER_IRQ_EN
    bus.irq_line    = 8'd2;
`endif
    model_reset();

    // Power-on reset
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;

    // Scroll 0, three spaced lines
    step("f0.vs", 1, 0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step("f0.hl", 0, 1, 8'h00);
      chk("f0.tile_n", 32'(bus.tile_line), 32'(i));
      step("f0.gap", 0, 0, 8'h00);
    end
    chk("f0.fscroll0", 32'(bus.frame_scroll), 32'h00);

    // Scroll 0x0B, 4th line -> eff 14
    step("f1.vs", 1, 0, 8'h0B);
    for (int i = 0; i < 4; i++) step("f1.hl", 0, 1, 8'h0B);
    chk("f1.map3",  32'(bus.map_row),   32'd1);
    chk("f1.tile3", 32'(bus.tile_line), 32'd6);

    // Scroll 0xFA, wrap across the map bottom
    step("f2.vs", 1, 0, 8'hFA);
    for (int i = 0; i < 11; i++) begin
      step("f2.hl", 0, 1, 8'hFA);
      if (i == 5) begin
        chk("f2.map5",  32'(bus.map_row),   32'd31);
        chk("f2.tile5", 32'(bus.tile_line), 32'd7);
      end
    end
    chk("f2.map10",  32'(bus.map_row),   32'd0);
    chk("f2.tile10", 32'(bus.tile_line), 32'd4);

    // Scroll change mid-frame is deferred to the next vsync
    step("f3.vs", 1, 0, 8'h10);
    for (int i = 0; i < 6; i++) step("f3.hl", 0, 1, 8'h10);
    step("f3.chg", 0, 0, 8'h80);
    step("f3.hl6", 0, 1, 8'h80);
    chk("f3.map6",  32'(bus.map_row),   32'd2);
    chk("f3.tile6", 32'(bus.tile_line), 32'd6);
    step("f4.vs", 1, 0, 8'h80);
    step("f4.hl0", 0, 1, 8'h80);
    chk("f4.map0", 32'(bus.map_row), 32'd16);

    // Full frame: 241 back-to-back lines, only 240 serviced
    step("f5.vs", 1, 0, 8'h33);
    cnt_valid = 0;
    for (int i = 0; i < 241; i++) begin
      step("f5.hl", 0, 1, 8'h33);
      if (bus.line_valid === 1'b1) cnt_valid++;
      if (i == 239) chk("f5.active_fall", 32'(bus.frame_active), 32'd0);
    end
    chk("f5.count", 32'(cnt_valid), 32'd240);
    step("f5.idle", 0, 1, 8'h33);

    // Simultaneous vsync+hline, then asynchronous reset mid-frame
    step("f6.vshl", 1, 1, 8'h20);
    chk("f6.map0",  32'(bus.map_row),   32'd4);
    chk("f6.tile0", 32'(bus.tile_line), 32'd0);
    cnt_irq = 0;
    for (int i = 0; i < 5; i++) begin
      step("f6.hl", 0, 1, 8'h20);
`ifdef SCROLL_RASTER_IRQ_EN
      if (bus.raster_irq === 1'b1) cnt_irq++;
`endif
    end
`ifdef SCROLL_RASTER_IRQ_EN
    chk("f6.irq_once", 32'(cnt_irq), 32'd1);
`endif
    bus.vsync_start = 1'b0;
    bus.hline_start = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step("post_rst.hl", 0, 1, 8'h55);
    step("post_rst.vs", 1, 0, 8'h55);
    step("post_rst.hl0", 0, 1, 8'h55);

    // Random traffic: occasional vsync (short frames), dense hline, noisy scroll
    for (int i = 0; i < 3000; i++) begin
      cur_sy = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 63) == 0) irq_sel = int'($urandom_range(0, 15));
      step("rand", ($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), cur_sy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
